// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect4 controller: board geometry, FSM state
// encoding, detector status codes and a column-full helper.
package connect4_pkg;

  localparam int BOARD_COLS = 4;
  localparam int BOARD_ROWS = 4;

  // ctrl_state encoding, also shown on the debug LEDs
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SELECT = 3'd1;
  localparam logic [2:0] ENC_COMMIT = 3'd2;
  localparam logic [2:0] ENC_SETTLE = 3'd3;
  localparam logic [2:0] ENC_CHECK  = 3'd4;
  localparam logic [2:0] ENC_OVER   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ENC_IDLE,
    S_SELECT = ENC_SELECT,
    S_COMMIT = ENC_COMMIT,
    S_SETTLE = ENC_SETTLE,
    S_CHECK  = ENC_CHECK,
    S_OVER   = ENC_OVER
  } state_t;

  // winner detector status codes
  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_P1   = 2'b01;
  localparam logic [1:0] ST_P2   = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;

  // A column is full when its top cell (row 3, index 12+col) is occupied
  function automatic logic col_full(input logic [15:0] board, input logic [1:0] col);
    return board[{2'b11, col}];
  endfunction

endpackage

// File: rtl/autodrop_picker.sv
// Picks the column for a timeout auto-drop: first non-full column starting
// at the cursor and wrapping 3->0. all_full flags a board with no legal move.
module autodrop_picker
  import connect4_pkg::*;
(
  input  logic [15:0] gameboard,
  input  logic [1:0]  cursor,
  output logic [1:0]  pick_col,
  output logic        all_full
);

  logic [1:0] cand;

  // Scan from the farthest offset back to the cursor so the nearest legal column wins
  always_comb begin
    pick_col = cursor;
    all_full = 1'b1;
    cand     = '0;
    for (int k = BOARD_COLS - 1; k >= 0; k--) begin
      cand = cursor + 2'(k);
      if (!col_full(gameboard, cand)) begin
        pick_col = cand;
        all_full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect4 turn sequencer: cursor handling, drop validation, move strobe,
// settle wait, win/draw check and per-move timeout with auto-drop.
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMR_W          = 26
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  input  logic [15:0] gameboard,
  input  logic [1:0]  game_status,
  output logic        move_en,
  output logic [3:0]  move_col,
  output logic [1:0]  cursor_col,
  output logic        player_turn,
  output logic        invalid_move,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  ctrl_state
);

  localparam bit               TMO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       settle_cnt;
  logic [1:0]       pick_col;
  logic             all_full;
  logic             top_full;
  logic             timeout_hit;

  autodrop_picker u_pick (
    .gameboard (gameboard),
    .cursor    (cursor_col),
    .pick_col  (pick_col),
    .all_full  (all_full)
  );

  assign top_full    = &gameboard[15:12];
  assign timeout_hit = TMO_EN && (tmr == TMR_LAST);
  assign ctrl_state  = state;

  // Game FSM with both counters; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cursor_col   <= '0;
      move_col     <= '0;
      player_turn  <= 1'b0;
      winner       <= ST_PLAY;
      move_en      <= 1'b0;
      invalid_move <= 1'b0;
      game_over    <= 1'b0;
      tmr          <= '0;
      settle_cnt   <= '0;
    end else begin
      move_en      <= 1'b0;
      invalid_move <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state       <= S_SELECT;
            cursor_col  <= '0;
            player_turn <= 1'b0;
            winner      <= ST_PLAY;
            game_over   <= 1'b0;
            tmr         <= '0;
          end
        end
        S_SELECT: begin
          if (btn_drop && !col_full(gameboard, cursor_col)) begin
            // drop wins over cursor buttons and uses the pre-move cursor
            move_col <= {2'b00, cursor_col};
            state    <= S_COMMIT;
          end else begin
            if (btn_drop)
              invalid_move <= 1'b1;
            else if (btn_left && !btn_right && cursor_col != 2'd0)
              cursor_col <= cursor_col - 2'd1;
            else if (btn_right && !btn_left && cursor_col != 2'd3)
              cursor_col <= cursor_col + 2'd1;
            // a rejected drop does not count as activity for the timeout
            if (!btn_drop && (btn_left || btn_right)) begin
              tmr <= '0;
            end else if (timeout_hit) begin
              tmr <= '0;
              if (all_full) begin
                state <= S_CHECK;
              end else begin
                move_col <= {2'b00, pick_col};
                state    <= S_COMMIT;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          move_en    <= 1'b1;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= S_CHECK;
          else                           settle_cnt <= settle_cnt + 4'd1;
        end
        S_CHECK: begin
          if (game_status != ST_PLAY) begin
            state     <= S_OVER;
            winner    <= game_status;
            game_over <= 1'b1;
          end else if (top_full) begin
            state     <= S_OVER;
            winner    <= ST_DRAW;
            game_over <= 1'b1;
          end else begin
            state       <= S_SELECT;
            player_turn <= ~player_turn;
            tmr         <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Scoreboard bench: a game-level model predicts timed events (invalid pulse,
// move strobe, turn change, game end); a negedge monitor pops and compares.
module tb_connect4_turn_controller;

  localparam int S = 3;
  localparam int T = 20;
  localparam int P_IDLE = 0, P_SEL = 1, P_BUSY = 2, P_OVER = 3;
  localparam int K_INV = 0, K_MOVE = 1, K_TURN = 2, K_OVER = 3;

  typedef struct { int kind; int at; int a; int b; int c; } ev_t;

  logic        clk = 1'b0;
  logic        reset, start, btn_left, btn_right, btn_drop;
  logic [15:0] gameboard;
  logic [1:0]  game_status;
  logic        move_en, player_turn, invalid_move, game_over;
  logic [3:0]  move_col;
  logic [1:0]  cursor_col, winner;
  logic [2:0]  ctrl_state;

  connect4_turn_controller #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .btn_left(btn_left),
    .btn_right(btn_right), .btn_drop(btn_drop), .gameboard(gameboard),
    .game_status(game_status), .move_en(move_en), .move_col(move_col),
    .cursor_col(cursor_col), .player_turn(player_turn), .invalid_move(invalid_move),
    .game_over(game_over), .winner(winner), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  bit   mon_en = 1'b0;
  logic last_pt, last_go;

  // game-level model
  int ph, m_cursor, m_player, idle, chk_at, stat_plan;
  int force_stat = -1;
  int h[4];

  function automatic string kname(input int k);
    case (k)
      K_INV:   return "invalid";
      K_MOVE:  return "move";
      K_TURN:  return "turn";
      default: return "over";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.at = at; e.a = a; e.b = b; e.c = c;
    q.push_back(e);
  endtask

  task automatic got(input int kind, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s at cycle %0d (a=%0d b=%0d c=%0d)", kname(kind), cyc, a, b, c);
    end else begin
      e = q[0];
      q.delete(0);
      if (e.kind != kind || e.at != cyc || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL %s: got %s cyc=%0d a=%0d b=%0d c=%0d, expected %s cyc=%0d a=%0d b=%0d c=%0d",
                 kname(e.kind), kname(kind), cyc, a, b, c, kname(e.kind), e.at, e.a, e.b, e.c);
      end
    end
  endtask

  function automatic logic [15:0] board_of();
    logic [15:0] b;
    b = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < h[c]; r++) b[r*4 + c] = 1'b1;
    return b;
  endfunction

  function automatic int pick_status();
    if (force_stat >= 0) return force_stat;
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic commit(input int n, input int col);
    push(K_MOVE, n + 2, col, m_player, m_cursor);
    h[col]++;
    ph = P_BUSY;
    chk_at = n + 2 + S;
    stat_plan = pick_status();
  endtask

  task automatic timeout_drop(input int n);
    int col;
    col = -1;
    for (int k = 0; k < 4; k++)
      if (col < 0 && h[(m_cursor + k) % 4] < 4) col = (m_cursor + k) % 4;
    if (col >= 0) commit(n, col);
    else begin
      ph = P_BUSY;
      chk_at = n + 1;
      stat_plan = pick_status();
    end
  endtask

  // drive one cycle of inputs and advance the model by the same cycle
  task automatic step(input bit s, input bit l, input bit r, input bit d);
    int n;
    n = cyc;
    start = s; btn_left = l; btn_right = r; btn_drop = d;
    gameboard = board_of();
    game_status = (ph == P_BUSY) ? 2'(stat_plan) : 2'b00;
    case (ph)
      P_IDLE, P_OVER: if (s) begin
        if (m_player != 0) push(K_TURN, n + 1, 0, 0, 0);
        ph = P_SEL; m_player = 0; m_cursor = 0; idle = 0;
      end
      P_SEL: begin
        if (d && h[m_cursor] < 4) commit(n, m_cursor);
        else begin
          if (d) push(K_INV, n + 1, 0, 0, 0);
          else if (l && !r) m_cursor = (m_cursor > 0) ? m_cursor - 1 : 0;
          else if (r && !l) m_cursor = (m_cursor < 3) ? m_cursor + 1 : 3;
          if (!d && (l || r)) idle = 0;
          else if (idle == T - 1) timeout_drop(n);
          else idle++;
        end
      end
      default: if (n == chk_at) begin
        if (stat_plan != 0) begin
          ph = P_OVER; push(K_OVER, n + 1, stat_plan, 0, 0);
        end else if (h[0] == 4 && h[1] == 4 && h[2] == 4 && h[3] == 4) begin
          ph = P_OVER; push(K_OVER, n + 1, 3, 0, 0);
        end else begin
          ph = P_SEL; m_player = 1 - m_player; idle = 0;
          push(K_TURN, n + 1, m_player, 0, 0);
        end
      end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic run_until(input int want, input int maxc, output int cnt);
    cnt = 0;
    while (ph != want && cnt < maxc) begin
      step(0, 0, 0, 0);
      cnt++;
    end
    if (ph != want) begin
      checks++; errors++;
      $display("FAIL run_until: phase %0d not reached in %0d cycles", want, maxc);
    end
  endtask

  // monitor: flags overdue expectations, then compares every observed event
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (q.size() > 0 && q[0].at < cyc) begin
          checks++; errors++;
          $display("FAIL missing %s due at cycle %0d (now %0d)", kname(q[0].kind), q[0].at, cyc);
          q.delete(0);
        end
        if (invalid_move) got(K_INV, 0, 0, 0);
        if (move_en) got(K_MOVE, int'(move_col), int'(player_turn), int'(cursor_col));
        if (player_turn !== last_pt) got(K_TURN, int'(player_turn), 0, 0);
        if (game_over && !last_go) got(K_OVER, int'(winner), 0, 0);
        last_pt = player_turn;
        last_go = game_over;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},   int'(ctrl_state), 0);
    chk({tag, "_cursor"},  int'(cursor_col), 0);
    chk({tag, "_movecol"}, int'(move_col), 0);
    chk({tag, "_player"},  int'(player_turn), 0);
    chk({tag, "_winner"},  int'(winner), 0);
    chk({tag, "_move_en"}, int'(move_en), 0);
    chk({tag, "_invalid"}, int'(invalid_move), 0);
    chk({tag, "_over"},    int'(game_over), 0);
  endtask

  initial begin
    int cnt;
    int late;
    int rate;
    bit s, l, r, d;
    reset = 1'b0; start = 0; btn_left = 0; btn_right = 0; btn_drop = 0;
    gameboard = '0; game_status = 2'b00;
    ph = P_IDLE; m_cursor = 0; m_player = 0; idle = 0; chk_at = 0; stat_plan = 0;
    for (int c = 0; c < 4; c++) h[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    last_pt = player_turn; last_go = game_over; mon_en = 1'b1;

    // cursor saturation
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    chk("cursor_sat_right", int'(cursor_col), 3);
    step(0, 1, 0, 0);
    chk("cursor_left", int'(cursor_col), 2);

    // legal drop on an empty board, turn hands over
    step(0, 0, 0, 1);
    run_until(P_SEL, 30, cnt);
    chk("turn_after_move", int'(player_turn), 1);

    // drop into a full column is rejected
    h[1] = 4;
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("invalid_stays_select", int'(ctrl_state), 1);
    chk("invalid_keeps_turn", int'(player_turn), 1);

    // timeout auto-drop wraps from col 3 to col 0
    h[3] = 4; h[0] = 0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    run_until(P_BUSY, 40, cnt);
    chk("timeout_len", cnt, T);
    chk("autodrop_state", int'(ctrl_state), 2);
    chk("autodrop_col", int'(move_col), 0);
    run_until(P_SEL, 30, cnt);

    // P2 win during settle ends the game; buttons ignored; restart
    step(0, 1, 0, 0);
    force_stat = 2;
    step(0, 0, 0, 1);
    run_until(P_OVER, 30, cnt);
    force_stat = -1;
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 2);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    chk("over_frozen_state", int'(ctrl_state), 5);
    chk("over_frozen_cursor", int'(cursor_col), 2);
    step(1, 0, 0, 0);
    chk("restart_winner", int'(winner), 0);
    chk("restart_state", int'(ctrl_state), 1);
    chk("restart_over", int'(game_over), 0);

    // async reset while in COMMIT suppresses the strobe
    for (int c = 0; c < 4; c++) h[c] = 0;
    step(0, 0, 0, 1);
    chk("commit_state", int'(ctrl_state), 2);
    mon_en = 1'b0;
    reset = 1'b0;
    start = 0; btn_left = 0; btn_right = 0; btn_drop = 0; game_status = 2'b00;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    ph = P_IDLE; m_cursor = 0; m_player = 0; idle = 0;
    for (int c = 0; c < 4; c++) h[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    last_pt = player_turn; last_go = game_over; mon_en = 1'b1;
    repeat (4) step(0, 0, 0, 0);

    // last move fills the top row with status 00: draw
    step(1, 0, 0, 0);
    h[0] = 4; h[1] = 4; h[2] = 4; h[3] = 3;
    repeat (3) step(0, 0, 1, 0);
    force_stat = 0;
    step(0, 0, 0, 1);
    run_until(P_OVER, 30, cnt);
    force_stat = -1;
    chk("draw_winner", int'(winner), 3);

    // randomized play, alternating busy and quiet phases
    for (int i = 0; i < 4000; i++) begin
      rate = (((i / 500) % 2) == 1) ? 40 : 6;
      s = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, rate - 1) == 0);
      r = ($urandom_range(0, rate - 1) == 0);
      d = ($urandom_range(0, rate) == 0);
      if ((ph == P_IDLE || ph == P_OVER) && $urandom_range(0, 3) == 0) begin
        s = 1'b1;
        for (int c = 0; c < 4; c++) h[c] = $urandom_range(0, 4);
      end
      step(s, l, r, d);
    end
    repeat (10) step(0, 0, 0, 0);

    late = 0;
    foreach (q[i]) if (q[i].at < cyc) late++;
    chk("scoreboard_drained", late, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
